// File: rtl/prefetch_buffer_if.sv
// Memory read port and decode-side handshake of the prefetch queue.
interface prefetch_buffer_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_error;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_addr;
   logic        instr_fault;

   modport master (
      output mem_req, mem_addr,
      input  mem_rvalid, mem_rdata, mem_error,
      output instr_valid, instr, instr_addr, instr_fault,
      input  instr_ready
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_rvalid, mem_rdata, mem_error,
      input  instr_valid, instr, instr_addr, instr_fault,
      output instr_ready
   );
endinterface

// File: rtl/prefetch_buffer.sv
// Sequential instruction prefetch queue with flush redirect.
// Define PREFETCH_STATS_EN to add fetched/discarded counters.
module prefetch_buffer #(
   parameter int unsigned DEPTH        = 4,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] flush_addr,
`ifdef PREFETCH_STATS_EN
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_discarded,
`endif
   prefetch_buffer_if.master bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD, HALT} state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   data_q  [DEPTH];
   logic [31:0]   addr_q  [DEPTH];
   logic          fault_q [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;
   logic          empty;
   logic          push;
   logic          pop;

   assign empty = (count == '0);
   assign push  = (state == WAIT) && bus.mem_rvalid && !flush;
   assign pop   = bus.instr_valid && bus.instr_ready;

   // Gating with rst keeps the port quiet while reset is held.
   assign bus.mem_req = rst && (state == IDLE) &&
                        (count < FULL) && !flush;
   assign bus.mem_addr    = fetch_pc;
   assign bus.instr_valid = !empty;
   assign bus.instr       = empty ? '0 : data_q[rd_ptr];
   assign bus.instr_addr  = empty ? '0 : addr_q[rd_ptr];
   assign bus.instr_fault = empty ? 1'b0 : fault_q[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_VECTOR;
      end else if (flush) begin
         fetch_pc <= {flush_addr[31:2], 2'b00};
         unique case (state)
            WAIT, DISCARD:
               state <= bus.mem_rvalid ? IDLE : DISCARD;
            IDLE, HALT:
               state <= IDLE;
         endcase
      end else begin
         unique case (state)
            IDLE:
               if (bus.mem_req) state <= WAIT;
            WAIT:
               if (bus.mem_rvalid) begin
                  if (bus.mem_error) begin
                     state <= HALT;
                  end else begin
                     state    <= IDLE;
                     fetch_pc <= fetch_pc + 32'd4;
                  end
               end
            DISCARD:
               if (bus.mem_rvalid) state <= IDLE;
            HALT:
               state <= HALT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr]  <= bus.mem_rdata;
         addr_q[wr_ptr]  <= fetch_pc;
         fault_q[wr_ptr] <= bus.mem_error;
      end
   end

`ifdef PREFETCH_STATS_EN
   logic drop;

   // Any response that arrives while its result is no longer wanted.
   assign drop = bus.mem_rvalid &&
                 ((state == DISCARD) || ((state == WAIT) && flush));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_fetched   <= '0;
         stat_discarded <= '0;
      end else begin
         if (push) stat_fetched   <= stat_fetched + 32'd1;
         if (drop) stat_discarded <= stat_discarded + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_prefetch_buffer.sv
// Randomized bench for prefetch_buffer against a queue-based model.
module tb_prefetch_buffer;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RV    = 32'h0000_0000;

   typedef struct {
      logic [31:0] d;
      logic [31:0] a;
      logic        f;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_addr = '0;

   prefetch_buffer_if bus();

`ifdef PREFETCH_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_discarded;
`endif

   prefetch_buffer #(
      .DEPTH(DEPTH),
      .RESET_VECTOR(RV)
   ) dut (
      .clk(clk),
      .rst(rst_n),
      .flush(flush),
      .flush_addr(flush_addr),
`ifdef PREFETCH_STATS_EN
      .stat_fetched(stat_fetched),
      .stat_discarded(stat_discarded),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // model: queue of accepted words plus fetch bookkeeping
   ent_t        m_q[$];
   logic [31:0] m_pc = RV;
   bit          m_out, m_want, m_halt;
   logic [31:0] m_fetched, m_disc;

   // memory: one pending access with a countdown
   bit          mp;
   int          md;
   logic [31:0] ma;
   bit          me;
   int          lat_min = 1, lat_max = 1;
   int          err_pct = 0, spur_pct = 0;
   logic [31:0] err_addr = 32'h1;

   logic [31:0] req_log[$];
   int          req_cyc[$];
   ent_t        pop_log[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rq(int i);
      return (i >= 0 && i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] pa(int i);
      return (i < pop_log.size()) ? pop_log[i].a : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] pd(int i);
      return (i < pop_log.size()) ? pop_log[i].d : 32'hxxxx_xxxx;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pc = RV;
      m_out = 0;
      m_want = 0;
      m_halt = 0;
      m_fetched = '0;
      m_disc = '0;
   endtask

   task automatic step();
      bit   rv, deliver, exp_req, exp_valid;
      ent_t head;
      deliver = mp && (md == 0);
      rv = deliver;
      if (!mp && spur_pct > 0 && $urandom_range(99) < spur_pct) rv = 1;
      bus.mem_rvalid = rv;
      bus.mem_rdata  = deliver ? (ma ^ 32'hA5A5_A5A5) :
                       (rv ? $urandom : 32'h0);
      bus.mem_error  = deliver ? me : (rv ? 1'($urandom_range(1)) : 1'b0);
      #1;
      if (!rst_n) model_reset();
      exp_req = rst_n && !m_halt && !m_out &&
                (m_q.size() < DEPTH) && !flush;
      exp_valid = m_q.size() > 0;
      head = exp_valid ? m_q[0] : '{d: '0, a: '0, f: 1'b0};
      chk("mem_req", bus.mem_req, exp_req);
      chk("mem_addr", bus.mem_addr, m_pc);
      chk("instr_valid", bus.instr_valid, exp_valid);
      chk("instr", bus.instr, head.d);
      chk("instr_addr", bus.instr_addr, head.a);
      chk("instr_fault", bus.instr_fault, head.f);
`ifdef PREFETCH_STATS_EN
      chk("stat_fetched", stat_fetched, m_fetched);
      chk("stat_discarded", stat_discarded, m_disc);
`endif
      if (bus.mem_req) begin
         req_log.push_back(bus.mem_addr);
         req_cyc.push_back(cyc);
      end
      if (bus.instr_valid && bus.instr_ready)
         pop_log.push_back('{d: bus.instr, a: bus.instr_addr,
                             f: bus.instr_fault});
      if (rst_n) begin
         if (exp_valid && bus.instr_ready) void'(m_q.pop_front());
         if (flush) begin
            m_q.delete();
            m_pc = {flush_addr[31:2], 2'b00};
            m_halt = 0;
            if (m_out) begin
               if (rv) begin
                  m_out = 0;
                  m_disc++;
               end else begin
                  m_want = 0;
               end
            end
         end else if (m_out && rv) begin
            m_out = 0;
            if (m_want) begin
               m_q.push_back('{d: bus.mem_rdata, a: m_pc, f: bus.mem_error});
               m_fetched++;
               if (bus.mem_error) m_halt = 1;
               else m_pc = m_pc + 32'd4;
            end else begin
               m_disc++;
            end
         end else if (exp_req) begin
            m_out = 1;
            m_want = 1;
         end
      end
      if (deliver) mp = 0;
      if (bus.mem_req) begin
         mp = 1;
         ma = bus.mem_addr;
         md = $urandom_range(lat_max, lat_min) - 1;
         me = (ma == err_addr) || ($urandom_range(99) < err_pct);
      end else if (mp && md > 0) begin
         md--;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_flush(logic [31:0] a);
      flush = 1;
      flush_addr = a;
      step();
      flush = 0;
      req_log.delete();
      req_cyc.delete();
      pop_log.delete();
   endtask

   initial begin
      bit found, ffound, fval;
      int rst_cnt;
      model_reset();
      bus.instr_ready = 1;
      bus.mem_rvalid = 0;
      bus.mem_rdata = '0;
      bus.mem_error = 0;
      @(negedge clk);

      // reset values and sequential fetch
      step();
      step();
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_instr_valid", bus.instr_valid, 0);
      rst_n = 1;
      repeat (12) step();
      chk("A_req0", rq(0), 32'h0);
      chk("A_req1", rq(1), 32'h4);
      chk("A_req2", rq(2), 32'h8);
      chk("A_spacing", (req_cyc.size() > 1) ? req_cyc[1] - req_cyc[0] : -1, 2);
      chk("A_pop0_addr", pa(0), 32'h0);
      chk("A_pop0_data", pd(0), 32'hA5A5_A5A5);
      chk("A_pop1_data", pd(1), 32'hA5A5_A5A1);

      // backpressure fills exactly DEPTH entries
      bus.instr_ready = 0;
      do_flush(32'h0);
      repeat (24) step();
      chk("B_nreq", req_log.size(), 4);
      chk("B_req3", rq(3), 32'hC);
      bus.instr_ready = 1;
      step();
      bus.instr_ready = 0;
      req_log.delete();
      repeat (6) step();
      chk("B_nreq_pop", req_log.size(), 1);
      chk("B_req_pop", rq(0), 32'h10);

      // flush while the access to 0x8 is outstanding
      lat_min = 3;
      lat_max = 3;
      bus.instr_ready = 1;
      do_flush(32'h0);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (req_log.size() > 0 && req_log[$] == 32'h8) found = 1;
      end
      chk("C_wait_req8", found, 1);
      do_flush(32'h103);
      repeat (14) step();
      chk("C_req0", rq(0), 32'h100);
      chk("C_pop0", pa(0), 32'h100);

      // fault halts fetch until redirect
      lat_min = 1;
      lat_max = 1;
      err_addr = 32'h20;
      do_flush(32'h10);
      repeat (30) step();
      ffound = 0;
      fval = 0;
      foreach (pop_log[i])
         if (pop_log[i].a == 32'h20) begin
            ffound = 1;
            fval = pop_log[i].f;
         end
      chk("D_fault_seen", ffound, 1);
      chk("D_fault_flag", fval, 1);
      chk("D_nreq", req_log.size(), 5);
      chk("D_last_req", rq(req_log.size() - 1), 32'h20);
      err_addr = 32'h1;
      do_flush(32'h40);
      repeat (4) step();
      chk("D_resume", rq(0), 32'h40);

      // address wrap
      do_flush(32'hFFFF_FFFC);
      repeat (8) step();
      chk("E_req0", rq(0), 32'hFFFF_FFFC);
      chk("E_req1", rq(1), 32'h0);

      // reset in the middle of an access
      lat_min = 3;
      lat_max = 3;
      do_flush(32'h200);
      for (int i = 0; i < 20 && req_log.size() == 0; i++) step();
      chk("F_req_seen", req_log.size(), 1);
      rst_n = 0;
      #1;
      chk("F_rst_mem_req", bus.mem_req, 0);
      chk("F_rst_mem_addr", bus.mem_addr, RV);
      chk("F_rst_valid", bus.instr_valid, 0);
      @(negedge clk);
      step();
      step();
      rst_n = 1;
      req_log.delete();
      repeat (10) step();
      chk("F_restart", rq(0), RV);

      // randomized traffic
      lat_min = 1;
      lat_max = 4;
      err_pct = 3;
      spur_pct = 10;
      rst_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) rst_n = 1;
         end else if ($urandom_range(999) < 3) begin
            rst_n = 0;
            rst_cnt = $urandom_range(2, 1);
         end
         flush = rst_n && ($urandom_range(99) < 6);
         flush_addr = ($urandom_range(3) == 0) ?
                      32'hFFFF_FFF0 + $urandom_range(15) : $urandom;
         bus.instr_ready = $urandom_range(99) < 60;
         step();
      end
      flush = 0;
      rst_n = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
